// File: rtl/ineq_tally_pkg.sv
// Shared constants for the inequality tally block: defaults, class bit positions,
// FSM encodings and the cls decode helper used by both RTL and bench.
package ineq_tally_pkg;

  localparam int WINDOW_DEF = 16;
  localparam int CW_DEF     = 5;
  localparam int NUM_W      = 4;
  localparam int CLS_W      = 3;

  localparam int CLS_LOW  = 2;
  localparam int CLS_MID  = 1;
  localparam int CLS_HIGH = 0;

  localparam logic [NUM_W-1:0] NUM_MIN_RST = 4'hF;
  localparam logic [NUM_W-1:0] NUM_MAX_RST = 4'h0;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_REPORT  = 2'd2;

  // Order matches the counter bank index in the top level.
  typedef enum logic [1:0] {
    KIND_LOW  = 2'd0,
    KIND_MID  = 2'd1,
    KIND_HIGH = 2'd2,
    KIND_ERR  = 2'd3
  } cls_kind_e;

  localparam logic [CLS_W-1:0] CLS_LOW_CODE  = 3'b001 << CLS_LOW;
  localparam logic [CLS_W-1:0] CLS_MID_CODE  = 3'b001 << CLS_MID;
  localparam logic [CLS_W-1:0] CLS_HIGH_CODE = 3'b001 << CLS_HIGH;

  function automatic cls_kind_e classify(input logic [CLS_W-1:0] cls);
    cls_kind_e kind;
    kind = KIND_ERR;
    if (cls == CLS_LOW_CODE)       kind = KIND_LOW;
    else if (cls == CLS_MID_CODE)  kind = KIND_MID;
    else if (cls == CLS_HIGH_CODE) kind = KIND_HIGH;
    return kind;
  endfunction

endpackage

// File: rtl/ineq_tally_tally_ctr.sv
// Up-counter with synchronous clear (priority over enable) and async reset.
module tally_ctr #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] q
);

  logic [CW-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/ineq_tally.sv
// Collects WINDOW valid classifier samples, tallies each class plus malformed
// codes, tracks min/max num, and reports the registered totals with a done pulse.
module ineq_tally
  import ineq_tally_pkg::*;
#(
  parameter int WINDOW = WINDOW_DEF,
  parameter int CW     = CW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [NUM_W-1:0] num,
  input  logic [CLS_W-1:0] cls,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    cnt_low,
  output logic [CW-1:0]    cnt_mid,
  output logic [CW-1:0]    cnt_high,
  output logic [CW-1:0]    cnt_err,
  output logic [NUM_W-1:0] num_min,
  output logic [NUM_W-1:0] num_max
);

  localparam int IW = $clog2(WINDOW);
  localparam logic [IW-1:0] LAST_IDX = IW'(WINDOW - 1);

  logic [1:0]       r_state;
  logic [IW-1:0]    r_idx;
  logic [NUM_W-1:0] r_min;
  logic [NUM_W-1:0] r_max;

  logic             w_accept;
  logic             w_sample;
  logic             w_last;
  logic [1:0]       w_kind;
  logic [3:0]       w_en;
  logic [CW-1:0]    w_cnt [4];

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_sample = (r_state == ST_COLLECT) && in_valid;
  assign w_last   = w_sample && (r_idx == LAST_IDX);
  assign w_kind   = classify(cls);

  // One counter per class kind; exactly one is enabled per accepted sample.
  for (genvar gi = 0; gi < 4; gi++) begin : g_ctr
    assign w_en[gi] = w_sample && (w_kind == 2'(gi));

    tally_ctr #(
      .CW(CW)
    ) u_ctr (
      .clk(clk),
      .rst(rst),
      .clr(w_accept),
      .en (w_en[gi]),
      .q  (w_cnt[gi])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (start) r_state <= ST_COLLECT;
        ST_COLLECT: if (w_last) r_state <= ST_REPORT;
        ST_REPORT:  r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (w_accept || w_last) begin
      r_idx <= '0;
    end else if (w_sample) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // Error samples still carry a real num, so they feed min/max too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_min <= NUM_MIN_RST;
      r_max <= NUM_MAX_RST;
    end else if (w_accept) begin
      r_min <= NUM_MIN_RST;
      r_max <= NUM_MAX_RST;
    end else if (w_sample) begin
      if (num < r_min) r_min <= num;
      if (num > r_max) r_max <= num;
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_REPORT);
  assign cnt_low  = w_cnt[KIND_LOW];
  assign cnt_mid  = w_cnt[KIND_MID];
  assign cnt_high = w_cnt[KIND_HIGH];
  assign cnt_err  = w_cnt[KIND_ERR];
  assign num_min  = r_min;
  assign num_max  = r_max;

endmodule
